// File: rtl/reg_xchg_pkg.sv
// reg_xchg_pkg: shared encodings for the exchange register file.
// The optional rotate feature is selected with REG_XCHG_ROTATE_EN.
package reg_xchg_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_SWAP   = 2'd1,
    OP_ROTATE = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_xchg_if.sv
// reg_xchg_if: command port plus combinational read port of reg_xchg_file.
// The requester owns the master modport, the register file the slave modport.
interface reg_xchg_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_a;
  logic [AW-1:0]    cmd_b;
  logic [WIDTH-1:0] cmd_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, rd_addr,
    input  cmd_ready, rd_data, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, rd_addr,
    output cmd_ready, rd_data, done, err
  );
endinterface

// File: rtl/reg_xchg_ctrl.sv
// reg_xchg_ctrl: command sequencing for reg_xchg_file. Produces cmd_ready,
// the per-cycle rotate shift enable and the done/err pulses. With
// REG_XCHG_ROTATE_EN undefined no rotate state or counter exists and
// ROTATE is rejected like any other bad command.
module reg_xchg_ctrl
  import reg_xchg_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  op_e           op,
  input  logic [AW-1:0] k,
  input  logic          bad,
  output logic          cmd_ready,
  output logic          shift_en,
  output logic          done,
  output logic          err
);

`ifdef REG_XCHG_ROTATE_EN

  state_e        state;
  logic [AW-1:0] cnt;
  logic          rot_go;

  // First shift lands on the accepting edge; k == 0 is a plain no-op command.
  assign rot_go    = accept && (op == OP_ROTATE) && !bad && (k != '0);
  assign cmd_ready = !rst && (state == ST_IDLE);
  assign shift_en  = !rst && (rot_go || (state == ST_ROT));

  // Command FSM: single-step commands finish on accept, long rotates count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (rot_go && (k > AW'(1))) begin
              state <= ST_ROT;
              cnt   <= k - 1'b1;
            end else begin
              done <= 1'b1;
              err  <= bad;
            end
          end
        end
        ST_ROT: begin
          cnt <= cnt - 1'b1;
          if (cnt == AW'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`else

  logic unused_k;
  assign unused_k  = ^k;
  assign cmd_ready = !rst;
  assign shift_en  = 1'b0;

  // Every accepted command completes next cycle; ROTATE is unsupported here.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= accept;
      err  <= accept && (bad || (op == OP_ROTATE));
    end
  end

`endif

endmodule

// File: rtl/reg_xchg_file.sv
// reg_xchg_file: DEPTH x WIDTH register file with atomic load, swap, clear
// and whole-file rotate, plus a combinational read port. Rotate support is
// compiled in with REG_XCHG_ROTATE_EN (see reg_xchg_ctrl).
module reg_xchg_file
  import reg_xchg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  reg_xchg_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0][WIDTH-1:0] regs_nxt;
  op_e  op;
  logic accept;
  logic a_oob;
  logic b_oob;
  logic bad;
  logic shift_en;

  assign op     = op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign a_oob  = int'(bus.cmd_a) >= DEPTH;
  assign b_oob  = int'(bus.cmd_b) >= DEPTH;

  // An out-of-range index rejects the command and leaves the file alone.
  always_comb begin
    bad = 1'b0;
    case (op)
      OP_LOAD:   bad = a_oob;
      OP_SWAP:   bad = a_oob || b_oob;
      OP_ROTATE: bad = b_oob;
      default:   bad = 1'b0;
    endcase
  end

  reg_xchg_ctrl #(.AW(AW)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .op        (op),
    .k         (bus.cmd_b),
    .bad       (bad),
    .cmd_ready (bus.cmd_ready),
    .shift_en  (shift_en),
    .done      (bus.done),
    .err       (bus.err)
  );

  // Next-state of the whole file; every update reads only pre-edge values,
  // which is what makes swap and rotate atomic.
  always_comb begin
    regs_nxt = regs;
    if (shift_en) begin
      regs_nxt = {regs[DEPTH-2:0], regs[DEPTH-1]};
    end else if (accept && !bad) begin
      case (op)
        OP_LOAD: regs_nxt[bus.cmd_a] = bus.cmd_data;
        OP_SWAP: begin
          regs_nxt[bus.cmd_a] = regs[bus.cmd_b];
          regs_nxt[bus.cmd_b] = regs[bus.cmd_a];
        end
        OP_CLEAR: regs_nxt = '0;
        default: ;
      endcase
    end
  end

  // Storage; reset also wipes contents mid-rotate.
  always_ff @(posedge clk) begin
    if (rst) regs <= '0;
    else     regs <= regs_nxt;
  end

  assign bus.rd_data = (int'(bus.rd_addr) < DEPTH) ? regs[bus.rd_addr] : '0;

endmodule

// File: tb/tb_reg_xchg_file.sv
// tb_reg_xchg_file: drives a DEPTH=4 and a DEPTH=3 instance from shared
// command fields; expected results come from an index-arithmetic model and
// are checked by per-instance monitors whenever done/err is seen.
module tb_reg_xchg_file;
  import reg_xchg_pkg::*;

`ifdef REG_XCHG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef logic [3:0][3:0] file_t;
  typedef struct { bit err; file_t file; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v4 = 1'b0, v3 = 1'b0;
  logic [1:0] op = '0, a = '0, b = '0;
  logic [3:0] data = '0;

  reg_xchg_if #(.WIDTH(4), .DEPTH(4)) b4 ();
  reg_xchg_if #(.WIDTH(4), .DEPTH(3)) b3 ();

  assign b4.cmd_valid = v4;
  assign b4.cmd_op    = op;
  assign b4.cmd_a     = a;
  assign b4.cmd_b     = b;
  assign b4.cmd_data  = data;
  assign b3.cmd_valid = v3;
  assign b3.cmd_op    = op;
  assign b3.cmd_a     = a;
  assign b3.cmd_b     = b;
  assign b3.cmd_data  = data;

  reg_xchg_file #(.WIDTH(4), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  reg_xchg_file #(.WIDTH(4), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  exp_t  q4[$], q3[$];
  file_t m4 = '0, m3 = '0;
  int    n_pass = 0, n_chk = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic bit is_bad(int d, int o, int ia, int ib);
    case (o)
      0: return ia >= d;
      1: return ia >= d || ib >= d;
      2: return !ROT_EN || ib >= d;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: rotating by k moves entry i to (i+k) mod d.
  function automatic file_t apply(file_t s, int d, int o, int ia, int ib, logic [3:0] v);
    file_t r = s;
    if (is_bad(d, o, ia, ib)) return s;
    case (o)
      0: r[ia] = v;
      1: begin r[ia] = s[ib]; r[ib] = s[ia]; end
      2: for (int i = 0; i < d; i++) r[(i + ib) % d] = s[i];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(int o, int ia, int ib, logic [3:0] v, bit en3);
    int  w = 0;
    int  lo = 0;
    bit  bad4;
    @(negedge clk);
    while (!(b4.cmd_ready && b3.cmd_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(w < 50), 1);
    op = o[1:0]; a = ia[1:0]; b = ib[1:0]; data = v;
    v4 = 1'b1; v3 = en3;
    @(posedge clk);
    #1;
    v4 = 1'b0; v3 = 1'b0;
    bad4 = is_bad(4, o, ia, ib);
    m4 = apply(m4, 4, o, ia, ib, v);
    q4.push_back('{bad4, m4});
    if (en3) begin
      m3 = apply(m3, 3, o, ia, ib, v);
      q3.push_back('{is_bad(3, o, ia, ib), m3});
    end
    if (o == 2) begin
      w = 0;
      @(negedge clk);
      while (!b4.cmd_ready && w < 20) begin
        lo++; w++;
        @(negedge clk);
      end
      chk($sformatf("rot k=%0d ready_low_cycles", ib), lo,
          (ROT_EN && !bad4 && ib >= 2) ? ib - 1 : 0);
    end
  endtask

  // Monitor for the DEPTH=4 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b4.done === 1'b1 || b4.err === 1'b1) begin
        if (q4.size() == 0) begin
          n_chk++;
          $display("FAIL dut4 done: unexpected pulse done=%0b err=%0b", b4.done, b4.err);
        end else begin
          e = q4.pop_front();
          chk("dut4 done", b4.done, 1);
          chk("dut4 err", b4.err, e.err);
          for (int i = 0; i < 4; i++) begin
            b4.rd_addr = i[1:0];
            #1;
            chk($sformatf("dut4 rd[%0d]", i), b4.rd_data, e.file[i]);
          end
        end
      end
    end
  end

  // Monitor for the DEPTH=3 instance; index 3 must read as zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b3.done === 1'b1 || b3.err === 1'b1) begin
        if (q3.size() == 0) begin
          n_chk++;
          $display("FAIL dut3 done: unexpected pulse done=%0b err=%0b", b3.done, b3.err);
        end else begin
          e = q3.pop_front();
          chk("dut3 done", b3.done, 1);
          chk("dut3 err", b3.err, e.err);
          for (int i = 0; i < 4; i++) begin
            b3.rd_addr = i[1:0];
            #1;
            chk($sformatf("dut3 rd[%0d]", i), b3.rd_data, (i < 3) ? e.file[i] : 4'd0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst ready4", b4.cmd_ready, 0);
    chk("rst ready3", b3.cmd_ready, 0);
    chk("rst done4", b4.done, 0);
    chk("rst err4", b4.err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst ready4", b4.cmd_ready, 1);

    for (int i = 0; i < 4; i++) issue(0, i, 0, 4'(i + 1), 1'b1);
    issue(1, 0, 3, 4'd0, 1'b1);
    issue(1, 2, 2, 4'd0, 1'b1);
    issue(1, 0, 3, 4'd0, 1'b1);
    issue(2, 0, 3, 4'd0, 1'b1);
    issue(2, 0, 1, 4'd0, 1'b1);
    issue(2, 0, 0, 4'd0, 1'b1);
    issue(2, 0, 2, 4'd0, 1'b1);

`ifdef REG_XCHG_ROTATE_EN
    // Abort a k=3 rotate after its first shift.
    @(negedge clk);
    op = 2'd2; a = 2'd0; b = 2'd3; v4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rot rst ready4", b4.cmd_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m4 = '0; m3 = '0;
    @(negedge clk);
    chk("after abort ready4", b4.cmd_ready, 1);
    chk("after abort done4", b4.done, 0);
    issue(0, 1, 0, 4'd9, 1'b1);
`endif

    issue(3, 0, 0, 4'd0, 1'b1);

    for (int n = 0; n < 300; n++)
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 4'($urandom), 1'b1);

    repeat (6) @(negedge clk);
    chk("q4 drained", q4.size(), 0);
    chk("q3 drained", q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_xchg_file.md
# reg_xchg_file

Parametrised register file whose core operation is an atomic, same-edge exchange of register contents: swap two entries, or rotate the whole file. It generalises the two-register non-blocking swap to DEPTH entries of WIDTH bits, with load, clear and a valid/ready command port. It sits beside the datapath as a small scratch/permutation store, and any entry can be read back combinationally.

## Interface
- WIDTH, 4, bits per register (≥1)
- DEPTH, 4, number of registers (≥2, need not be a power of two)
- AW, $clog2(DEPTH), index width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_op  in  2  0 LOAD, 1 SWAP, 2 ROTATE, 3 CLEAR
- cmd_a  in  AW  target index (LOAD/SWAP)
- cmd_b  in  AW  second index (SWAP) / rotate amount k (ROTATE)
- cmd_data  in  WIDTH  LOAD value
- rd_addr  in  AW  read index
- rd_data  out  WIDTH  reg[rd_addr], combinational; 0 if rd_addr ≥ DEPTH
- done  out  1  one-cycle pulse, command complete
- err  out  1  one-cycle pulse coincident with done, command rejected

## Operation
- LOAD: reg[a] ← cmd_data.
- SWAP: reg[a] ← old reg[b] and reg[b] ← old reg[a] on the same edge, both using pre-edge values; a == b leaves the file unchanged without error.
- CLEAR: all entries ← 0.
- ROTATE by k: the whole file moves one position toward the higher index per cycle, with wrap-around (reg[i] ← reg[i-1], reg[0] ← reg[DEPTH-1]). Each step uses pre-edge values of every entry. k = 0 changes nothing.
- Error: any index ≥ DEPTH (a, or b for SWAP, or k for ROTATE) sets err. The file is unchanged.
- FSM states:
  - IDLE: cmd_ready = 1.
    - Accept LOAD/SWAP/CLEAR/error → stay in IDLE.
    - Accept ROTATE with k ≥ 2 → ROT with cnt = k-1.
  - ROT: cmd_ready = 0.
    - Each edge performs one shift and decrements cnt.
    - When cnt reaches 0, return to IDLE.
- Reset (including mid-ROTATE):
  - All entries = 0, state IDLE, cnt = 0.
  - done = 0 and err = 0.
  - cmd_ready = 0 while rst is high.
  - No done pulse is produced for an aborted command.

## Timing
- Single-step commands (LOAD, SWAP, CLEAR, ROTATE k ≤ 1, error):
  - Take effect on the accepting edge.
  - done is high the following cycle.
  - Throughput is one command per cycle; a done pulse can coincide with a new accept.
- ROTATE k ≥ 2:
  - The first shift happens on the accepting edge, the remaining k-1 shifts on consecutive edges.
  - cmd_ready is low for k-1 cycles.
  - done and cmd_ready are high together in the cycle after the final shift.
- rd_data reflects post-edge contents in the same cycle (no read latency). A read of an entry being written returns the old value until the edge.
- Inputs other than cmd_valid are don't-care when no command is accepted.

## Configuration
- REG_XCHG_ROTATE_EN defined:
  - ROTATE is supported.
  - The ROT state and the cnt register are instantiated.
- REG_XCHG_ROTATE_EN undefined:
  - cmd_op = 2 is treated as an error: err and done pulse, no change.
  - No ROT state or counter is built.
  - cmd_ready = !rst at all times.

## Structure
- Package reg_xchg_pkg holds:
  - the op encoding (LOAD/SWAP/ROTATE/CLEAR) as a 2-bit enum;
  - the FSM state enum (IDLE, ROT).
- One sub-module, reg_xchg_ctrl: the FSM and rotate countdown. It takes the accept strobe, op and k, and produces cmd_ready, the per-cycle shift enable, done and err.
- The storage array and its write mux stay in the top module.

## Test plan
WIDTH=4, DEPTH=4 unless stated.
- Reset, then LOAD 1,2,3,4 to indices 0..3 back-to-back → four consecutive done pulses; rd_data at 0..3 reads 1,2,3,4.
- SWAP a=0, b=3 → file 4,2,3,1 after one edge, done next cycle. SWAP a=2, b=2 → unchanged, err = 0.
- ROTATE k=3 on 1,2,3,4:
  - file reads 4,1,2,3 → 3,4,1,2 → 2,3,4,1 on successive edges;
  - cmd_ready low for 2 cycles;
  - done with cmd_ready on cycle 3.
- Assert rst mid-ROTATE k=3 after the first shift → all entries 0, no done, cmd_ready high the cycle after rst falls.
- DEPTH=3: SWAP a=0, b=3 and ROTATE k=3 → each gives an err+done pulse with the file unchanged. CLEAR → all 0.
- Build without REG_XCHG_ROTATE_EN: ROTATE k=1 → err+done pulse, file unchanged, cmd_ready never drops.
